// File: rtl/cic_pkg.sv
// Shared definitions for the CIC interpolator: gain-shift helper,
// round/saturate helper and the pending-sample state encoding.
package cic_pkg;

    localparam logic signed [15:0] SAT_MAX = 16'sh7FFF;
    localparam logic signed [15:0] SAT_MIN = 16'sh8000;

    typedef enum logic {
        PEND_EMPTY = 1'b0,
        PEND_FULL  = 1'b1
    } pend_state_t;

    // Right shift that brings the CIC DC gain (R*M)^N / R back to 1.
    function automatic int cic_gs(input int n, input int r, input int m);
        return n * $clog2(r * m) - $clog2(r);
    endfunction

    function automatic logic signed [15:0] round_sat(input logic signed [63:0] x,
                                                     input int gs);
        logic signed [63:0] t;
        if (gs > 0) begin
            t = (x + (64'sd1 <<< (gs - 1))) >>> gs;
        end else begin
            t = x;
        end
        if (t > longint'(SAT_MAX)) begin
            return SAT_MAX;
        end else if (t < longint'(SAT_MIN)) begin
            return SAT_MIN;
        end
        return 16'(t);
    endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One CIC comb: M-deep delay line and subtractor, advanced on en.
module cic_comb_stage #(
    parameter int W = 22,
    parameter int M = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic signed [W-1:0] in_data,
    output logic signed [W-1:0] out_data
);

    logic signed [W-1:0] dly [M];

    assign out_data = in_data - dly[M-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < M; i++) begin
                dly[i] <= '0;
            end
        end else if (en) begin
            dly[0] <= in_data;
            for (int i = 1; i < M; i++) begin
                dly[i] <= dly[i-1];
            end
        end
    end

endmodule

// File: rtl/cic_interp.sv
// CIC interpolator by R: N combs at the input rate, N integrators on hi_ce.
// Define CIC_ROUND_EN for round-half-up with saturation instead of truncation.
module cic_interp
    import cic_pkg::*;
#(
    parameter int IW = 16,
    parameter int N  = 3,
    parameter int R  = 8,
    parameter int M  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic signed [IW-1:0] in_data,
    input  logic                 hi_ce,
    output logic signed [IW-1:0] out_data,
    output logic                 out_valid,
    output logic                 overrun
);

    localparam int GS = cic_gs(N, R, M);
    localparam int W  = IW + GS;

    logic signed [W-1:0]  c0;
    logic signed [W-1:0]  comb_result;
    logic signed [W-1:0]  pend_data;
    logic signed [W-1:0]  inj;
    logic signed [IW-1:0] scaled;
    pend_state_t          pend_state;
    pend_state_t          pend_next;
    logic                 overrun_next;

    assign c0 = W'(in_data);

    for (genvar k = 0; k < N; k++) begin : g_comb
        logic signed [W-1:0] c_in;
        logic signed [W-1:0] c_out;
        if (k == 0) begin : g_first
            assign c_in = c0;
        end else begin : g_rest
            assign c_in = g_comb[k-1].c_out;
        end
        cic_comb_stage #(
            .W (W),
            .M (M)
        ) u_comb (
            .clk      (clk),
            .reset    (reset),
            .en       (in_valid),
            .in_data  (c_in),
            .out_data (c_out)
        );
    end

    assign comb_result = g_comb[N-1].c_out;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_data <= '0;
        end else if (in_valid) begin
            pend_data <= comb_result;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_state <= PEND_EMPTY;
            overrun    <= 1'b0;
        end else begin
            pend_state <= pend_next;
            overrun    <= overrun_next;
        end
    end

    // A coincident hi_ce takes the old sample, so a new one is then not an overrun.
    always_comb begin
        pend_next    = pend_state;
        overrun_next = 1'b0;
        if (in_valid) begin
            pend_next = PEND_FULL;
            if (pend_state == PEND_FULL && !hi_ce) begin
                overrun_next = 1'b1;
            end
        end else if (hi_ce) begin
            pend_next = PEND_EMPTY;
        end
    end

    assign inj = (pend_state == PEND_FULL) ? pend_data : '0;

    for (genvar k = 0; k < N; k++) begin : g_integ
        logic signed [W-1:0] acc;
        logic signed [W-1:0] acc_next;
        logic signed [W-1:0] addend;
        if (k == 0) begin : g_first
            assign addend = inj;
        end else begin : g_rest
            assign addend = g_integ[k-1].acc;
        end
        assign acc_next = hi_ce ? acc + addend : acc;
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                acc <= '0;
            end else begin
                acc <= acc_next;
            end
        end
    end

`ifdef CIC_ROUND_EN
    assign scaled = IW'(round_sat(64'(g_integ[N-1].acc_next), GS));
`else
    assign scaled = IW'(g_integ[N-1].acc_next >>> GS);
`endif

    // Scaling the post-update value makes out_data current while out_valid is high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= hi_ce;
            if (hi_ce) begin
                out_data <= scaled;
            end
        end
    end

endmodule

// File: tb/tb_cic_interp.sv
// Self-checking bench for cic_interp (IW=16, N=3, R=8, M=1): directed
// scenarios plus random traffic against a closed-form CIC model.
module tb_cic_interp;

    localparam int IW = 16;
    localparam int N  = 3;
    localparam int R  = 8;
    localparam int M  = 1;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 in_valid;
    logic signed [IW-1:0] in_data;
    logic                 hi_ce;
    logic signed [IW-1:0] out_data;
    logic                 out_valid;
    logic                 overrun;

    int total = 0;
    int bad   = 0;

    longint               xs[$];
    longint               inj_q[$];
    logic signed [15:0]   tick_out[$];
    bit                   pend;
    longint               pend_val;
    logic signed [15:0]   exp_out;
    logic                 exp_valid;
    logic                 exp_ovr;

    always #5 clk = ~clk;

    cic_interp #(
        .IW (IW),
        .N  (N),
        .R  (R),
        .M  (M)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .hi_ce     (hi_ce),
        .out_data  (out_data),
        .out_valid (out_valid),
        .overrun   (overrun)
    );

    // Internal width is 22 bits; reduce the exact integer result modulo 2^22.
    function automatic longint wrap_w(input longint v);
        longint w;
        w = v & ((64'sd1 <<< 22) - 1);
        if (w >= (64'sd1 <<< 21)) w = w - (64'sd1 <<< 22);
        return w;
    endfunction

    function automatic logic signed [15:0] scale_model(input longint v);
        longint w;
        longint t;
        w = wrap_w(v);
`ifdef CIC_ROUND_EN
        t = (w + 32) >>> 6;
        if (t > 32767) t = 32767;
        if (t < -32768) t = -32768;
`else
        t = w >>> 6;
`endif
        return 16'(t);
    endfunction

    // Third difference of the low-rate input history.
    function automatic longint comb_model();
        longint coef[4] = '{1, -3, 3, -1};
        longint s = 0;
        int n = xs.size();
        for (int j = 0; j < 4; j++) begin
            if (n - 1 - j >= 0) s += coef[j] * xs[n-1-j];
        end
        return s;
    endfunction

    // Three cascaded integrators: weight of injection s at tick T is C(T-s, 2).
    function automatic longint cic_model();
        longint s = 0;
        longint k;
        int t = inj_q.size() - 1;
        for (int i = 0; i <= t; i++) begin
            k = t - i;
            s += inj_q[i] * (k * (k - 1) / 2);
        end
        return s;
    endfunction

    task automatic check_output(input string tag, input logic signed [31:0] obs,
                                input logic signed [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic apply_stimulus(input bit iv, input longint d, input bit hc);
        in_valid = iv;
        in_data  = 16'(d);
        hi_ce    = hc;
        exp_ovr   = iv && pend && !hc;
        exp_valid = hc;
        if (hc) begin
            inj_q.push_back(pend ? pend_val : 0);
            pend    = 1'b0;
            exp_out = scale_model(cic_model());
        end
        if (iv) begin
            xs.push_back(longint'(in_data));
            pend_val = comb_model();
            pend     = 1'b1;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        hi_ce    = 1'b0;
        if (hc) tick_out.push_back(out_data);
        check_output("out_valid", out_valid, exp_valid);
        check_output("overrun", overrun, exp_ovr);
        check_output("out_data", out_data, exp_out);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        hi_ce    = 1'b0;
        #1;
        check_output("rst_out_data", out_data, 0);
        check_output("rst_out_valid", out_valid, 0);
        check_output("rst_overrun", overrun, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        xs.delete();
        inj_q.delete();
        tick_out.delete();
        pend     = 1'b0;
        pend_val = 0;
        exp_out  = '0;
    endtask

    task automatic run_period(input longint d);
        apply_stimulus(1'b1, d, 1'b0);
        for (int i = 0; i < R; i++) begin
            apply_stimulus(1'b0, 0, 1'b1);
            apply_stimulus(1'b0, 0, 1'b0);
        end
    endtask

    initial begin
        int imp[24] = '{1, 3, 6, 10, 15, 21, 28, 36, 42, 46, 48, 48,
                        46, 42, 36, 28, 21, 15, 10, 6, 3, 1, 0, 0};
        reset    = 1'b0;
        in_valid = 1'b0;
        hi_ce    = 1'b0;
        in_data  = '0;

        do_reset();

        // Impulse response
        run_period(64);
        for (int p = 0; p < 3; p++) run_period(0);
        for (int k = 0; k < 24; k++) check_output("impulse", tick_out[k+2], imp[k]);

        // DC, then reset in the middle of the stream
        do_reset();
        for (int p = 0; p < 5; p++) run_period(1000);
        for (int k = 24; k < 40; k++) check_output("dc", tick_out[k], 1000);
        apply_stimulus(1'b1, 1000, 1'b0);
        apply_stimulus(1'b0, 0, 1'b1);
        do_reset();
        for (int k = 0; k < 20; k++) begin
            apply_stimulus(1'b0, 0, 1'b1);
            check_output("post_reset", out_data, 0);
        end

        // Full scale, both polarities
        do_reset();
        for (int p = 0; p < 5; p++) run_period(-32768);
        for (int k = 24; k < 40; k++) check_output("fs_neg", tick_out[k], -32768);
        do_reset();
        for (int p = 0; p < 5; p++) run_period(32767);
        for (int k = 24; k < 40; k++) check_output("fs_pos", tick_out[k], 32767);

        // Overrun: second sample replaces the first
        do_reset();
        apply_stimulus(1'b1, 100, 1'b0);
        check_output("ovr_first", overrun, 0);
        apply_stimulus(1'b1, 200, 1'b0);
        check_output("ovr_pulse", overrun, 1);
        apply_stimulus(1'b0, 0, 1'b0);
        check_output("ovr_single", overrun, 0);
        for (int k = 0; k < 4; k++) apply_stimulus(1'b0, 0, 1'b1);
        check_output("ovr_inject", tick_out[2], -2);

        // Coincident in_valid and hi_ce with a pending sample
        do_reset();
        apply_stimulus(1'b1, 300, 1'b0);
        apply_stimulus(1'b1, -500, 1'b1);
        check_output("coinc_ovr", overrun, 0);
        for (int k = 0; k < 4; k++) apply_stimulus(1'b0, 0, 1'b1);
        check_output("coinc_out", tick_out[3], -8);

        // Random traffic
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset();
            apply_stimulus(($urandom % 6) == 0,
                           longint'($urandom_range(65535)) - 32768,
                           ($urandom % 2) == 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
